// File: rtl/peri_seq_if.sv
// Request/drive bundle between an access master and peri_seq; err exists only with PERI_SEQ_ADDR_ERR_EN.
interface peri_seq_if #(
  parameter int COL_NO      = 128,
  parameter int PAIR_ROW_NO = 64
);
  logic                           req;
  logic [$clog2(COL_NO)-1:0]      col_sel;
  logic [$clog2(PAIR_ROW_NO)-1:0] row_sel;
  logic                           row_half;
  logic                           ack;
  logic                           busy;
  logic                           done;
  logic [COL_NO-1:0]              col;
  logic [PAIR_ROW_NO-1:0]         row0;
  logic [PAIR_ROW_NO-1:0]         row1;
`ifdef PERI_SEQ_ADDR_ERR_EN
  logic                           err;
`endif

  modport master (
    output req, col_sel, row_sel, row_half,
    input  ack, busy, done, col, row0, row1
`ifdef PERI_SEQ_ADDR_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  req, col_sel, row_sel, row_half,
    output ack, busy, done, col, row0, row1
`ifdef PERI_SEQ_ADDR_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/peri_seq.sv
// One-hot column/row pulse sequencer: ack at T, SETUP, PULSE_W drive cycles, GAP_W recovery, done at T+2+PULSE_W+GAP_W.
// req is ignored (ack=0) while busy; PERI_SEQ_ADDR_ERR_EN adds err flagging out-of-range addresses in the DONE cycle.
module peri_seq #(
  parameter int COL_NO      = 128,
  parameter int PAIR_ROW_NO = 64,
  parameter int PULSE_W     = 4,
  parameter int GAP_W       = 1
) (
  input logic       clk,
  input logic       rst_n,
  peri_seq_if.slave bus
);
  localparam int CAW  = $clog2(COL_NO);
  localparam int RAW  = $clog2(PAIR_ROW_NO);
  localparam int MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNTW = $clog2(MAXW + 1);

  localparam logic [CNTW-1:0]        PULSE_LAST = CNTW'(PULSE_W - 1);
  localparam logic [CNTW-1:0]        GAP_LAST   = CNTW'(GAP_W - 1);
  localparam logic [COL_NO-1:0]      COL_ONE    = {{(COL_NO-1){1'b0}}, 1'b1};
  localparam logic [PAIR_ROW_NO-1:0] ROW_ONE    = {{(PAIR_ROW_NO-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, GAP, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [CAW-1:0]         col_sel_q;
  logic [RAW-1:0]         row_sel_q;
  logic                   row_half_q;
  logic [COL_NO-1:0]      col_q, col_d;
  logic [PAIR_ROW_NO-1:0] row0_q, row0_d;
  logic [PAIR_ROW_NO-1:0] row1_q, row1_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   acc;
  logic                   addr_ok;

  assign acc     = bus.req && (state_q == IDLE);
  assign addr_ok = (int'(col_sel_q) < COL_NO) && (int'(row_sel_q) < PAIR_ROW_NO);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (acc) state_d = SETUP;
      SETUP: begin
        state_d = PULSE;
        cnt_d   = '0;
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next state so they line up with the state they describe.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
    col_d  = '0;
    row0_d = '0;
    row1_d = '0;
    if ((state_d == PULSE) && addr_ok) begin
      col_d = COL_ONE << col_sel_q;
      if (row_half_q) row1_d = ROW_ONE << row_sel_q;
      else            row0_d = ROW_ONE << row_sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      col_sel_q  <= '0;
      row_sel_q  <= '0;
      row_half_q <= 1'b0;
      col_q      <= '0;
      row0_q     <= '0;
      row1_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc) begin
        col_sel_q  <= bus.col_sel;
        row_sel_q  <= bus.row_sel;
        row_half_q <= bus.row_half;
      end
      col_q  <= col_d;
      row0_q <= row0_d;
      row1_q <= row1_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

`ifdef PERI_SEQ_ADDR_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= (state_d == DONE) && !addr_ok;
  end

  assign bus.err = err_q;
`endif

  assign bus.ack  = acc;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.col  = col_q;
  assign bus.row0 = row0_q;
  assign bus.row1 = row1_q;
endmodule

// File: tb/tb_peri_seq.sv
// Bench for peri_seq: per-cycle expected output frames are queued when a request is driven and popped at each negedge.
module tb_peri_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  peri_seq_if #(.COL_NO(128), .PAIR_ROW_NO(64)) bus_a ();
  peri_seq_if #(.COL_NO(100), .PAIR_ROW_NO(10)) bus_b ();

  peri_seq #(.COL_NO(128), .PAIR_ROW_NO(64), .PULSE_W(4), .GAP_W(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  peri_seq #(.COL_NO(100), .PAIR_ROW_NO(10), .PULSE_W(1), .GAP_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct packed {
    logic         ack;
    logic         busy;
    logic         done;
    logic [127:0] col;
    logic [63:0]  r0;
    logic [63:0]  r1;
  } fa_t;

  typedef struct packed {
    logic        ack;
    logic        busy;
    logic        done;
    logic        err;
    logic [99:0] col;
    logic [9:0]  r0;
    logic [9:0]  r1;
  } fb_t;

  fa_t qa[$];
  fb_t qb[$];
  int  total = 0;
  int  bad   = 0;

  function automatic fa_t obs_a();
    return {bus_a.ack, bus_a.busy, bus_a.done, bus_a.col, bus_a.row0, bus_a.row1};
  endfunction

  function automatic fb_t obs_b();
    logic e;
`ifdef PERI_SEQ_ADDR_ERR_EN
    e = bus_b.err;
`else
    e = 1'b0;
`endif
    return {bus_b.ack, bus_b.busy, bus_b.done, e, bus_b.col, bus_b.row0, bus_b.row1};
  endfunction

  // Frames for ack cycle, SETUP, 4 PULSE, 1 GAP, DONE.
  function automatic void push_a(input int c, input int r, input int h);
    fa_t f;
    f = '0; f.ack = 1'b1; qa.push_back(f);
    f = '0; f.busy = 1'b1; qa.push_back(f);
    for (int i = 0; i < 4; i++) begin
      f = '0; f.busy = 1'b1; f.col[c] = 1'b1;
      if (h != 0) f.r1[r] = 1'b1; else f.r0[r] = 1'b1;
      qa.push_back(f);
    end
    f = '0; f.busy = 1'b1; qa.push_back(f);
    f = '0; f.busy = 1'b1; f.done = 1'b1; qa.push_back(f);
  endfunction

  // Frames for ack cycle, SETUP, 1 PULSE, 3 GAP, DONE; out-of-range keeps lines low.
  function automatic void push_b(input int c, input int r, input int h);
    fb_t f;
    logic oor;
    oor = (c >= 100) || (r >= 10);
    f = '0; f.ack = 1'b1; qb.push_back(f);
    f = '0; f.busy = 1'b1; qb.push_back(f);
    f = '0; f.busy = 1'b1;
    if (!oor) begin
      f.col[c] = 1'b1;
      if (h != 0) f.r1[r] = 1'b1; else f.r0[r] = 1'b1;
    end
    qb.push_back(f);
    for (int i = 0; i < 3; i++) begin
      f = '0; f.busy = 1'b1; qb.push_back(f);
    end
    f = '0; f.busy = 1'b1; f.done = 1'b1;
`ifdef PERI_SEQ_ADDR_ERR_EN
    f.err = oor;
`endif
    qb.push_back(f);
  endfunction

  task automatic set_a(input int c, input int r, input int h);
    bus_a.col_sel  = 7'(c);
    bus_a.row_sel  = 6'(r);
    bus_a.row_half = 1'(h);
  endtask

  task automatic scramble_a();
    set_a(int'($urandom_range(127)), int'($urandom_range(63)), int'($urandom_range(1)));
  endtask

  task automatic test_reset();
    fa_t oa;
    fb_t ob;
    rst_n = 1'b0;
    bus_a.req = 1'b0; set_a(0, 0, 0);
    bus_b.req = 1'b0; bus_b.col_sel = '0; bus_b.row_sel = '0; bus_b.row_half = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      oa = obs_a(); ob = obs_b();
      total++;
      if (oa !== '0) begin bad++; $display("FAIL reset_a k=%0d got=%h exp=0", k, oa); end
      total++;
      if (ob !== '0) begin bad++; $display("FAIL reset_b k=%0d got=%h exp=0", k, ob); end
      repeat (2) @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single(input string name, input int c, input int r, input int h);
    fa_t o, e;
    push_a(c, r, h);
    qa.push_back('0);
    bus_a.req = 1'b1; set_a(c, r, h);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      o = obs_a(); e = qa.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL %s cyc=T+%0d got=%h exp=%h", name, i, o, e); end
      @(posedge clk); #1;
      bus_a.req = 1'b0; scramble_a();
    end
  endtask

  task automatic test_back_to_back();
    fa_t o, e;
    for (int k = 0; k < 3; k++) push_a(k * 30 + 1, k * 20 + 2, k % 2);
    qa.push_back('0);
    bus_a.req = 1'b1; set_a(1, 2, 0);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      o = obs_a(); e = qa.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL back_to_back cyc=T+%0d got=%h exp=%h", i, o, e); end
      @(posedge clk); #1;
      if (((i + 1) % 8 == 0) && (i < 23)) set_a(((i + 1) / 8) * 30 + 1, ((i + 1) / 8) * 20 + 2, ((i + 1) / 8) % 2);
      else scramble_a();
      if (i == 23) bus_a.req = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    fa_t o, e;
    push_a(9, 4, 1);
    bus_a.req = 1'b1; set_a(9, 4, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      o = obs_a(); e = qa.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL reset_mid_pre cyc=T+%0d got=%h exp=%h", i, o, e); end
      @(posedge clk); #1;
      bus_a.req = 1'b0;
    end
    qa.delete();
    rst_n = 1'b0;
    #1;
    o = obs_a();
    total++;
    if (o !== '0) begin bad++; $display("FAIL reset_mid_async got=%h exp=0", o); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      o = obs_a();
      total++;
      if (o !== '0) begin bad++; $display("FAIL reset_mid_hold k=%0d got=%h exp=0", i, o); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.req = 1'b1; set_a(50, 30, 0);
    push_a(50, 30, 0);
    qa.push_back('0);
    #1;
    o = obs_a(); e = qa.pop_front();
    total++;
    if (o !== e) begin bad++; $display("FAIL reset_mid_ack got=%h exp=%h", o, e); end
    for (int i = 1; i < 9; i++) begin
      @(posedge clk); #1;
      bus_a.req = 1'b0; scramble_a();
      @(negedge clk);
      o = obs_a(); e = qa.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL reset_mid_post cyc=T+%0d got=%h exp=%h", i, o, e); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_short_pulse_addr_range();
    fb_t o, e;
    int bc[4] = '{7, 120, 3, 99};
    int br[4] = '{9, 2, 12, 0};
    int bh[4] = '{1, 0, 1, 0};
    for (int k = 0; k < 4; k++) push_b(bc[k], br[k], bh[k]);
    qb.push_back('0);
    bus_b.req = 1'b1;
    bus_b.col_sel = 7'(bc[0]); bus_b.row_sel = 4'(br[0]); bus_b.row_half = 1'(bh[0]);
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      o = obs_b(); e = qb.pop_front();
      total++;
      if (o !== e) begin bad++; $display("FAIL short_pulse_range cyc=T+%0d got=%h exp=%h", i, o, e); end
      @(posedge clk); #1;
      if (((i + 1) % 7 == 0) && (i < 27)) begin
        bus_b.col_sel  = 7'(bc[(i + 1) / 7]);
        bus_b.row_sel  = 4'(br[(i + 1) / 7]);
        bus_b.row_half = 1'(bh[(i + 1) / 7]);
      end else begin
        bus_b.col_sel  = 7'($urandom_range(127));
        bus_b.row_sel  = 4'($urandom_range(15));
        bus_b.row_half = 1'($urandom_range(1));
      end
      if (i == 27) bus_b.req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single("basic_row0", 5, 3, 0);
    test_single("max_row1", 127, 63, 1);
    test_back_to_back();
    test_reset_mid();
    test_short_pulse_addr_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/peri_seq.md
PERI_SEQ -- requirements
Module: peri_seq

Interface
REQ-001 SHALL have parameter COL_NO, default 128, number of array columns (≥2, need not be a power of two).
REQ-002 SHALL have parameter PAIR_ROW_NO, default 64, number of row pairs (≥2, need not be a power of two).
REQ-003 SHALL have parameter PULSE_W, default 4, cycles the selected lines are driven (≥1).
REQ-004 SHALL have parameter GAP_W, default 1, recovery cycles after the pulse (≥1).
REQ-005 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req  input  1  access request.
REQ-008 SHALL have port col_sel  input  $clog2(COL_NO)  column address.
REQ-009 SHALL have port row_sel  input  $clog2(PAIR_ROW_NO)  row-pair address.
REQ-010 SHALL have port row_half  input  1  0 selects row0, 1 selects row1 of the pair.
REQ-011 SHALL have port ack  output  1  request accepted this cycle.
REQ-012 SHALL have port busy  output  1  sequence in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port col  output  COL_NO  one-hot column drive.
REQ-015 SHALL have port row0, row1  output  PAIR_ROW_NO each  one-hot row drive.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, PULSE, GAP, DONE.
REQ-017 ack SHALL be combinational req AND (state==IDLE); req in any other state SHALL be ignored with ack=0.
REQ-018 On ack at cycle T, col_sel/row_sel/row_half SHALL be latched; address inputs SHALL be don't-care afterwards.
REQ-019 SETUP SHALL last exactly 1 cycle (T+1) with all drive lines 0.
REQ-020 PULSE SHALL last exactly PULSE_W cycles (T+2..T+1+PULSE_W); col bit col_sel and bit row_sel of row0 (row_half=0) or row1 (row_half=1) SHALL be 1, all other bits 0.
REQ-021 GAP SHALL last exactly GAP_W cycles with all drive lines 0.
REQ-022 DONE SHALL last 1 cycle with done=1, then return to IDLE; earliest next ack is the cycle after DONE.
REQ-023 busy SHALL be 1 in SETUP, PULSE, GAP, DONE; 0 in IDLE.
REQ-024 col, row0, row1, busy, done SHALL be registered outputs (no combinational path from inputs).
REQ-025 Out-of-range latched address (col_sel≥COL_NO or row_sel≥PAIR_ROW_NO) SHALL complete the full sequence with identical timing but keep all drive lines 0 throughout.
REQ-026 At most one col bit and one row bit across row0|row1 SHALL ever be 1.
REQ-027 PULSE and GAP duration counters SHALL be sized $clog2(max(PULSE_W,GAP_W)+1) and SHALL not wrap.

Reset
REQ-028 rst_n=0 SHALL immediately (asynchronously) force state IDLE and col, row0, row1, busy, done (and err when present) to 0.
REQ-029 Reset asserted mid-sequence SHALL abort it with no done pulse; after release the block SHALL accept req on the first rising edge.
REQ-030 Latched address registers SHALL reset to 0.

Configuration
REQ-031 Macro PERI_SEQ_ADDR_ERR_EN defined SHALL add output err (1 bit) pulsing 1 in the DONE cycle of a sequence whose latched address was out of range, else 0.
REQ-032 Without PERI_SEQ_ADDR_ERR_EN the err port SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-033 PULSE_W=4, GAP_W=1: req=1, col_sel=5, row_sel=3, row_half=0 at T -> ack@T; col=1<<5, row0=1<<3, row1=0 during T+2..T+5; done@T+7; busy T+1..T+7.
REQ-034 row_half=1, col_sel=127, row_sel=63 -> only col[127] and row1[63] high for 4 cycles; row0 stays 0.
REQ-035 req held high continuously -> ack only at T, T+8, T+16; no ack while busy; no overlapping pulses.
REQ-036 COL_NO=100 with PERI_SEQ_ADDR_ERR_EN, col_sel=120 -> no drive lines high, done and err both 1 at T+7; legal access afterwards -> err=0.
REQ-037 rst_n pulsed low at T+3 of a sequence -> all outputs 0 immediately, no done; req at first edge after release -> ack, normal sequence.
REQ-038 PULSE_W=1, GAP_W=3 -> lines high only at T+2; done@T+6.
